// File: rtl/rns_forward_converter_if.sv
// Operand/residue bus of the binary-to-RNS forward converter, moduli {2^N-1, 2^N, 2^N+1}.
// Both channels use valid/ready: a transfer happens on the rising clock edge where valid and ready are both high.
interface rns_forward_converter_if #(
    parameter int N = 7
);
    logic           in_valid;
    logic           in_ready;
    logic [3*N-1:0] x_in;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   res_m1;
    logic [N-1:0]   res_p0;
    logic [N:0]     res_p1;

    modport master (
        output in_valid, x_in, out_ready,
        input  in_ready, out_valid, res_m1, res_p0, res_p1
    );

    modport slave (
        input  in_valid, x_in, out_ready,
        output in_ready, out_valid, res_m1, res_p0, res_p1
    );
endinterface

// File: rtl/rns_forward_converter.sv
// Iterative forward converter: binary operand -> residues mod 2^N-1, 2^N, 2^N+1.
// Uses only N+2-bit adds, end-around folds and conditional subtracts; one conversion per 5 cycles at best.
module rns_forward_converter #(
    parameter int N = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    rns_forward_converter_if.slave   bus,
    output logic [2:0]               dbg_state
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SUM  = 3'd1,
        FOLD = 3'd2,
        CORR = 3'd3,
        OUT  = 3'd4
    } state_t;

    localparam logic [N+1:0] MOD_M1 = (N+2)'((1 << N) - 1);
    localparam logic [N+1:0] MOD_P1 = (N+2)'((1 << N) + 1);

    state_t       state;
    logic [N+1:0] s;
    logic [N+1:0] t;
    logic [N-1:0] p0_reg;
    logic         out_valid_r;
    logic [N-1:0] res_m1_r;
    logic [N-1:0] res_p0_r;
    logic [N:0]   res_p1_r;

    logic [N+1:0] l_x;
    logic [N+1:0] m_x;
    logic [N+1:0] h_x;

    assign l_x = {2'b00, bus.x_in[N-1:0]};
    assign m_x = {2'b00, bus.x_in[2*N-1:N]};
    assign h_x = {2'b00, bus.x_in[3*N-1:2*N]};

    // 2^N == 1 mod 2^N-1 gives s = h+m+l; 2^N == -1 mod 2^N+1 gives t = l-m+h, offset by the modulus to stay positive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            s           <= '0;
            t           <= '0;
            p0_reg      <= '0;
            out_valid_r <= 1'b0;
            res_m1_r    <= '0;
            res_p0_r    <= '0;
            res_p1_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        p0_reg <= bus.x_in[N-1:0];
                        s      <= h_x + m_x + l_x;
                        t      <= l_x + h_x + MOD_P1 - m_x;
                        state  <= SUM;
                    end
                end
                SUM: begin
                    s <= {2'b00, s[N-1:0]} + {{N{1'b0}}, s[N+1:N]};
                    if (t >= MOD_P1) t <= t - MOD_P1;
                    state <= FOLD;
                end
                FOLD: begin
                    s <= {2'b00, s[N-1:0]} + {{(N+1){1'b0}}, s[N]};
                    if (t >= MOD_P1) t <= t - MOD_P1;
                    state <= CORR;
                end
                CORR: begin
                    // All-ones is the second representation of zero modulo 2^N-1.
                    res_m1_r    <= (s == MOD_M1) ? '0 : s[N-1:0];
                    res_p1_r    <= t[N:0];
                    res_p0_r    <= p0_reg;
                    out_valid_r <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid_r;
    assign bus.res_m1    = res_m1_r;
    assign bus.res_p0    = res_p0_r;
    assign bus.res_p1    = res_p1_r;
    assign dbg_state     = state;
endmodule

// File: tb/tb_rns_forward_converter.sv
// Bench for rns_forward_converter: directed corner cases plus a random sweep with backpressure,
// checked by a scoreboard against a plain modulo reference.
module tb_rns_forward_converter;
    localparam int N = 7;
    localparam int W = 3 * N + 1;  // packed triple {m1, p0, p1}

    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;
    int         ready_mode;        // 0 = hold low, 1 = hold high, 2 = random
    int         n_checks;
    int         n_fail;
    logic [W-1:0] exp_q[$];

    rns_forward_converter_if #(.N(N)) bus ();

    rns_forward_converter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] model(input logic [3*N-1:0] x);
        int v;
        v = int'(x);
        return {7'(v % 127), 7'(v % 128), 8'(v % 129)};
    endfunction

    function automatic logic [W-1:0] triple(input int m1, input int p0, input int p1);
        return {7'(m1), 7'(p0), 8'(p1)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // out_ready driver
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = ($urandom_range(0, 4) != 0);
            endcase
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(bus.out_valid), 32'd0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("triple", 32'({bus.res_m1, bus.res_p0, bus.res_p1}), 32'(e));
            end
        end
    end

    // driver tasks
    task automatic send(input logic [3*N-1:0] x, input logic [W-1:0] e);
        int k;
        bit done;
        bus.in_valid = 1'b1;
        bus.x_in     = x;
        k = 0;
        done = 1'b0;
        while (!done && k < 1000) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            k++;
        end
        bus.in_valid = 1'b0;
        bus.x_in     = $urandom_range(0, 2097151);
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] st, output bit ok);
        int k;
        k = 0;
        ok = 1'b0;
        while (!ok && k < 100) begin
            @(posedge clk);
            #1;
            k++;
            if (dbg_state == st) ok = 1'b1;
        end
    endtask

    initial begin
        int  edges;
        bit  ok;
        logic [3*N-1:0] x;

        n_checks     = 0;
        n_fail       = 0;
        ready_mode   = 1;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.x_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // reset state
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_triple", 32'({bus.res_m1, bus.res_p0, bus.res_p1}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        // latency with x_in = 0: accept edge plus three more
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.x_in     = '0;
        exp_q.push_back(triple(0, 0, 0));
        edges = 0;
        ok    = 1'b0;
        while (!ok && edges < 20) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            edges++;
            if (edges == 1) check("busy_in_ready", 32'(bus.in_ready), 32'd0);
            if (bus.out_valid) ok = 1'b1;
        end
        check("latency_edges", 32'(edges), 32'd4);
        drain();

        // directed values
        send(21'd12345,   triple(26, 57, 90));
        send(21'd127,     triple(0, 127, 127));
        send(21'd128,     triple(1, 0, 128));
        send(21'd2097151, triple(0, 127, 127));
        drain();

        // backpressure hold with an ignored in_valid pulse
        ready_mode = 0;
        @(posedge clk);
        #1;
        send(21'd12345, triple(26, 57, 90));
        wait_state(3'd4, ok);
        check("hold_reach_out", 32'(ok), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = (i == 2);
            bus.x_in     = 21'd5;
            @(negedge clk);
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_triple", 32'({bus.res_m1, bus.res_p0, bus.res_p1}), 32'(triple(26, 57, 90)));
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        ready_mode   = 1;
        drain();
        repeat (8) @(posedge clk);
        #1;
        check("pulse_ignored", 32'(bus.out_valid), 32'd0);
        check("held_after_hs", 32'({bus.res_m1, bus.res_p0, bus.res_p1}), 32'(triple(26, 57, 90)));

        // reset in FOLD discards the in-flight conversion
        bus.in_valid = 1'b1;
        bus.x_in     = 21'd777;
        wait_state(3'd2, ok);
        bus.in_valid = 1'b0;
        check("reach_fold", 32'(ok), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_triple", 32'({bus.res_m1, bus.res_p0, bus.res_p1}), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("postrst_in_ready", 32'(bus.in_ready), 32'd1);
        send(21'd300, triple(46, 44, 42));
        drain();

        // random sweep with random backpressure
        ready_mode = 2;
        for (int i = 0; i < 10000; i++) begin
            x = 21'($urandom_range(0, 2097151));
            send(x, model(x));
        end
        ready_mode = 1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
